// File: rtl/note_pkg.sv
// Shared definitions for the note scroll controller and the bitmap renderer:
// note code encodings, controller state encoding and slot geometry.
package note_pkg;

   localparam int SLOTS  = 10;
   localparam int NOTE_W = 7;

   typedef enum logic [1:0] {
      NOTE_EMPTY = 2'b00,
      NOTE_RED   = 2'b01,
      NOTE_BLUE  = 2'b10
   } note_code_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DRAIN = 2'd3
   } state_t;

endpackage

// File: rtl/note_scroll_ctrl_step_div.sv
// Scroll step divider: counts 0..STEP_DIV-1 while enabled, holds while
// disabled, clears on clr; step is high in the cycle the count is at its last
// value and the counter is enabled.
module scroll_step_div #(
   parameter int STEP_DIV = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic step
);

   localparam int            CW   = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // next count: clear wins, otherwise wrap at LAST when enabled
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
   end

   // counter register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign step = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/note_scroll_ctrl.sv
// Note scroll controller: owns scroll offset and red/blue slot masks, pulls
// one note code per full note-width scroll over a valid/ready handshake.
// Handshake: note_ready is high only in the RUN-state cycle where the slots
// shift; a transfer happens when note_valid and note_ready are both high, and
// a shift with note_valid low loads an empty slot and pulses underflow.
// Optional build macro HIT_JUDGE_EN adds button judging against slot 0.
module note_scroll_ctrl
   import note_pkg::*;
#(
   parameter int STEP_DIV = 500000,
   parameter int SLOTS    = note_pkg::SLOTS,
   parameter int NOTE_W   = note_pkg::NOTE_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             pause,
   input  logic             chart_end,
   input  logic             note_valid,
   input  logic [1:0]       note_code,
`ifdef HIT_JUDGE_EN
   input  logic             btn_red,
   input  logic             btn_blue,
   output logic             hit,
   output logic             miss,
   output logic [15:0]      score,
`endif
   output logic             note_ready,
   output logic [SLOTS-1:0] red_notes,
   output logic [SLOTS-1:0] blue_notes,
   output logic [2:0]       offset,
   output logic             frame_upd,
   output logic             underflow,
   output logic             busy,
   output state_t           dbg_state
);

   localparam logic [2:0] OFF_LAST = 3'(NOTE_W - 1);

   state_t           state_q, state_d;
   logic [SLOTS-1:0] red_q, red_d, blue_q, blue_d;
   logic [2:0]       offset_q, offset_d;
   logic             frame_upd_q, frame_upd_d;
   logic             underflow_q, underflow_d;
   logic             step, wrap, fetch, div_en, div_clr, drained;
   logic             ins_red, ins_blue;
`ifdef HIT_JUDGE_EN
   logic             hit_q, hit_d, miss_q, miss_d;
   logic [15:0]      score_q, score_d;
`endif

   scroll_step_div #(.STEP_DIV(STEP_DIV)) u_div (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (div_en),
      .clr  (div_clr),
      .step (step)
   );

   assign drained = (red_q == '0) && (blue_q == '0) && (offset_q == 3'd0);

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state: pause takes priority over chart_end in RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (pause) state_d = PAUSE;
                  else if (chart_end) state_d = DRAIN;
         PAUSE:   if (!pause) state_d = RUN;
         DRAIN:   if (drained) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: divider control, shift/fetch qualifiers, busy
   always_comb begin
      div_en  = (state_q == RUN) || ((state_q == DRAIN) && !pause);
      div_clr = (state_q == IDLE);
      wrap    = step && (offset_q == OFF_LAST);
      fetch   = wrap && (state_q == RUN);
      busy    = (state_q != IDLE);
   end

   // slot masks, offset, pulses and optional judge
   always_comb begin
      red_d       = red_q;
      blue_d      = blue_q;
      offset_d    = offset_q;
      frame_upd_d = step;
      underflow_d = fetch && !note_valid;
      ins_red     = fetch && note_valid && (note_code == NOTE_RED);
      ins_blue    = fetch && note_valid && (note_code == NOTE_BLUE);
`ifdef HIT_JUDGE_EN
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      score_d = score_q;
      // judge against slot 0 as registered, before any shift this cycle
      if (btn_red && btn_blue) begin
         miss_d = 1'b1;
      end else if (btn_red) begin
         if (red_q[0]) begin hit_d = 1'b1; red_d[0] = 1'b0; end
         else miss_d = 1'b1;
      end else if (btn_blue) begin
         if (blue_q[0]) begin hit_d = 1'b1; blue_d[0] = 1'b0; end
         else miss_d = 1'b1;
      end
      if (wrap && (red_q[0] || blue_q[0]) && !hit_d) miss_d = 1'b1;
      if (hit_d && (score_q != 16'hFFFF)) score_d = score_q + 16'd1;
      if ((state_q == IDLE) && start) score_d = '0;
`endif
      // the shift takes slot 1 from the registered masks, so it overwrites
      // any hit-clear of slot 0 made above
      if (step) begin
         if (offset_q == OFF_LAST) begin
            offset_d = 3'd0;
            red_d    = {ins_red,  red_q[SLOTS-1:1]};
            blue_d   = {ins_blue, blue_q[SLOTS-1:1]};
         end else begin
            offset_d = offset_q + 3'd1;
         end
      end
   end

   // datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         red_q       <= '0;
         blue_q      <= '0;
         offset_q    <= '0;
         frame_upd_q <= 1'b0;
         underflow_q <= 1'b0;
`ifdef HIT_JUDGE_EN
         hit_q       <= 1'b0;
         miss_q      <= 1'b0;
         score_q     <= '0;
`endif
      end else begin
         red_q       <= red_d;
         blue_q      <= blue_d;
         offset_q    <= offset_d;
         frame_upd_q <= frame_upd_d;
         underflow_q <= underflow_d;
`ifdef HIT_JUDGE_EN
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         score_q     <= score_d;
`endif
      end
   end

   assign note_ready = fetch;
   assign red_notes  = red_q;
   assign blue_notes = blue_q;
   assign offset     = offset_q;
   assign frame_upd  = frame_upd_q;
   assign underflow  = underflow_q;
   assign dbg_state  = state_q;
`ifdef HIT_JUDGE_EN
   assign hit   = hit_q;
   assign miss  = miss_q;
   assign score = score_q;
`endif

endmodule

// File: tb/tb_note_scroll_ctrl.sv
// Bench for note_scroll_ctrl with STEP_DIV=4. Frame contents and underflow
// expectations are queued by the driver and consumed by a monitor on
// frame_upd / note_ready.
module tb_note_scroll_ctrl;

   localparam int STEP_DIV = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0, start = 1'b0, pause = 1'b0, chart_end = 1'b0;
   logic       note_valid = 1'b0;
   logic [1:0] note_code = 2'b00;
   logic       note_ready, frame_upd, underflow, busy;
   logic [9:0] red_notes, blue_notes;
   logic [2:0] offset;
   logic [1:0] dbg_state;
`ifdef HIT_JUDGE_EN
   logic        btn_red = 1'b0, btn_blue = 1'b0, hit, miss;
   logic [15:0] score;
`endif

   int n_vec = 0;
   int n_bad = 0;
   logic [22:0] exp_q[$];
   logic        exp_uf_q[$];
   logic        chk_en = 1'b1;
   logic        uf_pend = 1'b0;
   logic        uf_exp = 1'b0;

   note_scroll_ctrl #(.STEP_DIV(STEP_DIV)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
      .chart_end(chart_end), .note_valid(note_valid), .note_code(note_code),
`ifdef HIT_JUDGE_EN
      .btn_red(btn_red), .btn_blue(btn_blue), .hit(hit), .miss(miss), .score(score),
`endif
      .note_ready(note_ready), .red_notes(red_notes), .blue_notes(blue_notes),
      .offset(offset), .frame_upd(frame_upd), .underflow(underflow),
      .busy(busy), .dbg_state(dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frames(input int n, output int cyc);
      int limit;
      limit = 10 * n + 20;
      cyc = 0;
      while (n > 0 && cyc < limit) begin
         @(negedge clk);
         cyc++;
         if (frame_upd) n--;
      end
      if (n > 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL frame_timeout: %0d frames missing after %0d cycles, expected 0", n, cyc);
      end
   endtask

   task automatic wait_ready();
      int cyc;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!note_ready && cyc < 60);
      check("ready_seen", note_ready, 1'b1);
   endtask

   // six mid-note frames with the pre-shift masks, then the shift frame
   task automatic push_shift(input logic [9:0] pr, input logic [9:0] pb,
                             input logic [9:0] qr, input logic [9:0] qb,
                             input logic fetch, input logic uf);
      for (int k = 1; k < 7; k++) exp_q.push_back({pr, pb, 3'(k)});
      exp_q.push_back({qr, qb, 3'd0});
      if (fetch) exp_uf_q.push_back(uf);
   endtask

   // monitor: consumes queued expectations on frame_upd / note_ready
   always @(negedge clk) begin
      logic [22:0] e;
      if (chk_en && rst_n) begin
         if (uf_pend) begin
            check("underflow", underflow, uf_exp);
            uf_pend = 1'b0;
         end else if (underflow) begin
            check("underflow_spurious", underflow, 1'b0);
         end
         if (note_ready) begin
            if (exp_uf_q.size() == 0) begin
               check("ready_spurious", note_ready, 1'b0);
            end else begin
               uf_exp  = exp_uf_q.pop_front();
               uf_pend = 1'b1;
            end
         end
         if (frame_upd) begin
            if (exp_q.size() == 0) begin
               check("frame_spurious", frame_upd, 1'b0);
            end else begin
               e = exp_q.pop_front();
               check("frame", {red_notes, blue_notes, offset}, e);
               check("overlap", red_notes & blue_notes, 10'h000);
            end
         end
      end
   end

   // driver
   initial begin
      int c;
      // reset state
      tick();
      tick();
      @(negedge clk);
      check("reset_outputs", {note_ready, red_notes, blue_notes, offset, frame_upd,
                              underflow, busy, dbg_state}, 32'h0);
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_busy", busy, 1'b0);

      // 1: red held, first note arrives after seven steps
      note_valid = 1'b1;
      note_code  = 2'b01;
      push_shift(10'h000, 10'h000, 10'h200, 10'h000, 1'b1, 1'b0);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_frames(1, c);
      check("first_step_latency", c, 5);
      wait_frames(1, c);
      check("step_period", c, 4);
      wait_frames(5, c);
      check("busy_run", busy, 1'b1);

      // 2: R, B, empty, R, code 11 as empty
      note_code = 2'b01; push_shift(10'h200, 10'h000, 10'h300, 10'h000, 1'b1, 1'b0); wait_frames(7, c);
      note_code = 2'b10; push_shift(10'h300, 10'h000, 10'h180, 10'h200, 1'b1, 1'b0); wait_frames(7, c);
      note_code = 2'b00; push_shift(10'h180, 10'h200, 10'h0C0, 10'h100, 1'b1, 1'b0); wait_frames(7, c);
      note_code = 2'b01; push_shift(10'h0C0, 10'h100, 10'h260, 10'h080, 1'b1, 1'b0); wait_frames(7, c);
      note_code = 2'b11; push_shift(10'h260, 10'h080, 10'h130, 10'h040, 1'b1, 1'b0); wait_frames(7, c);

      // 3: valid low at the shift -> underflow, empty slot
      note_valid = 1'b0;
      push_shift(10'h130, 10'h040, 10'h098, 10'h020, 1'b1, 1'b1);
      wait_frames(7, c);

      // 5: reset mid-scroll with non-zero masks
      exp_q.push_back({10'h098, 10'h020, 3'd1});
      exp_q.push_back({10'h098, 10'h020, 3'd2});
      wait_frames(2, c);
      note_valid = 1'b1;
      tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("midrun_reset", {note_ready, red_notes, blue_notes, offset, frame_upd,
                             underflow, busy, dbg_state}, 32'h0);
      repeat (10) tick();
      @(negedge clk);
      check("after_reset_idle", {busy, offset, red_notes}, 14'h0);

      // 4: blue note, start ignored in RUN, pause, then drain
      note_code = 2'b10;
      push_shift(10'h000, 10'h000, 10'h000, 10'h200, 1'b1, 1'b0);
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_frames(7, c);
      for (int k = 1; k < 4; k++) exp_q.push_back({10'h000, 10'h200, 3'(k)});
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_frames(3, c);
      tick();
      pause = 1'b1;
      repeat (10) tick();
      @(negedge clk);
      check("pause_state", {dbg_state, busy, offset, blue_notes}, {2'd2, 1'b1, 3'd3, 10'h200});
      repeat (10) tick();
      pause = 1'b0;
      exp_q.push_back({10'h000, 10'h200, 3'd4});
      wait_frames(1, c);
      check("resume_latency", c, 4);
      chart_end = 1'b1;
      note_code = 2'b01;
      exp_q.push_back({10'h000, 10'h200, 3'd5});
      exp_q.push_back({10'h000, 10'h200, 3'd6});
      exp_q.push_back({10'h000, 10'h100, 3'd0});
      for (int k = 2; k <= 10; k++) begin
         logic [9:0] pb, qb;
         pb = 10'h200 >> (k - 1);
         qb = 10'h200 >> k;
         push_shift(10'h000, pb, 10'h000, qb, 1'b0, 1'b0);
      end
      wait_frames(66, c);
      check("drain_state", dbg_state, 2'd3);
      tick();
      @(negedge clk);
      check("drain_to_idle", {busy, dbg_state}, 3'b000);
      chart_end = 1'b0;
      repeat (12) tick();
      @(negedge clk);
      check("idle_quiet", {busy, offset, red_notes, blue_notes}, 24'h0);

`ifdef HIT_JUDGE_EN
      // 6: judge
      chk_en = 1'b0;
      note_code = 2'b01;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_ready();
      wait_ready();
      note_code = 2'b00;
      repeat (8) wait_ready();
      tick();
      @(negedge clk);
      check("judge_slots", red_notes, 10'h003);
      btn_blue = 1'b1; tick(); btn_blue = 1'b0;
      @(negedge clk);
      check("wrong_colour", {hit, miss, red_notes}, {2'b01, 10'h003});
      btn_red = 1'b1; btn_blue = 1'b1; tick(); btn_red = 1'b0; btn_blue = 1'b0;
      @(negedge clk);
      check("both_buttons", {hit, miss}, 2'b01);
      btn_red = 1'b1; tick(); btn_red = 1'b0;
      @(negedge clk);
      check("hit", {hit, miss, score, red_notes}, {2'b10, 16'd1, 10'h002});
      wait_ready();
      @(negedge clk);
      check("empty_drop_no_miss", miss, 1'b0);
      wait_ready();
      @(negedge clk);
      check("unhit_drop_miss", miss, 1'b1);
      chk_en = 1'b1;
`endif

      check("frame_q_empty", exp_q.size(), 0);
      check("ready_q_empty", exp_uf_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
